hysteresis_tracker: RTL and testbench
=====================================

# hysteresis_tracker

Final Canny stage. Consumes the raster-ordered 2-bit edge-class stream from the local-mean threshold stage (strong/weak/none) and performs single-pass hysteresis: a weak pixel is promoted to an edge only if one of its 8 neighbours is strong. Emits one binary edge pixel per input pixel, in raster order, per frame. Two 2-bit line buffers supply the 3x3 class window; an internal flush drains the final row after the last input pixel.

## Interface

Parameters:
- IMG_W, 256, pixels per line (≥4)
- IMG_H, 256, lines per frame (≥3)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  **synchronous, active-low reset**
- in_valid  in  1  edge_type valid; accepted when in_valid && in_ready
- edge_type  in  2  10=strong, 01=weak, 00=none, 11 treated as none
- in_ready  out  1  low only during FLUSH
- out_valid  out  1  edge_out/edge_pix valid this cycle
- edge_out  out  1  1 = final edge
- edge_pix  out  8  255 if edge_out else 0
- frame_done  out  1  one-cycle pulse coincident with last output of the frame

## Operation

- Input counters col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel. col wraps to 0 and row increments at end of line.
- Line buffers hold rows r-1 and r-2 of classes. The window centre is the pixel at linear index n = k-IMG_W-1, where k is the current input index.
- Neighbours outside the image read as none: row -1, row IMG_H, col -1, col IMG_W. There is no column wrap. Stale line-buffer data is masked by the row counter, so buffers need no clearing.
- Decision:
  - centre strong → 1
  - centre weak and any neighbour strong → 1
  - else → 0
  - Single pass only; no weak-to-weak propagation.
- FSM:
  - RUN: accept input. Each accepted k ≥ IMG_W+1 produces an output for centre n.
  - RUN→FLUSH when index IMG_W*IMG_H-1 is accepted.
  - FLUSH: in_ready=0. Emit the remaining IMG_W+1 centres, one per cycle, with bottom/right padding as none.
  - FLUSH→RUN after the last emit. Counters clear and frame_done pulses with the final output.
- Exactly IMG_W*IMG_H outputs per frame.
- rst_n low at any point, including mid-frame or in FLUSH, discards the partial frame. The next accepted pixel is (0,0).

## Timing

- Reset values: out_valid=0, edge_out=0, edge_pix=0, frame_done=0, in_ready=1, state RUN, counters 0.
- Latency: the output for centre n is registered, with out_valid high the cycle after input n+IMG_W+1 is accepted.
- No accepted input means no output in RUN. Gaps in in_valid propagate as gaps; there is no backpressure on the output.
- FLUSH lasts exactly IMG_W+1 cycles with out_valid high every cycle. in_valid is ignored throughout.
- in_ready returns to 1 the cycle after the last flush output, so back-to-back frames lose IMG_W+1 cycles.
- Widths:
  - col is $clog2(IMG_W).
  - row is $clog2(IMG_H).
  - The flush counter is $clog2(IMG_W+2).

## Structure

- Shared package canny_pkg holds:
  - EDGE_NONE=2'b00
  - EDGE_WEAK=2'b01
  - EDGE_STRONG=2'b10
  - EDGE_PIX_ON=8'd255
- Sub-module linebuf_2b: single-port read-before-write delay line, depth IMG_W, width 2. It is instantiated twice and cascaded (row r-1 → row r-2), advancing on accepted input or flush step.
- Top level holds the counters, FSM, 3x3 window registers, border mask and decision logic.

## Test plan

All scenarios use IMG_W=8, IMG_H=4.

- Single strong pixel at (1,1), rest none, back-to-back → 32 outputs; only output index 9 has edge_out=1/edge_pix=255; frame_done on output 32.
- Weak at (2,3) with strong at (1,2) → index 19 edge=1. Isolated weak at (2,6) → index 22 edge=0. Code 11 everywhere → all 0.
- Strong at (1,7) and weak at (2,0) → index 16 edge=0 (no wrap). Weak at (2,6) → index 22 edge=1.
- Flush: after the 32nd accepted pixel, in_ready=0 for exactly 9 cycles with out_valid=1 each. Holding in_valid=1 during flush changes nothing. A second frame starts cleanly.
- Random 50% in_valid gaps → output sequence identical to the back-to-back run. Output count is 32 per frame.
- rst_n low for 1 cycle after 13 pixels → all outputs 0 during reset. The next frame matches the golden model from pixel (0,0).

Source files
------------

// File: rtl/canny_pkg.sv
// Shared edge-class encodings and helpers for the Canny pipeline stages.
package canny_pkg;

   localparam logic [1:0] EDGE_NONE    = 2'b00;
   localparam logic [1:0] EDGE_WEAK    = 2'b01;
   localparam logic [1:0] EDGE_STRONG  = 2'b10;
   localparam logic [7:0] EDGE_PIX_ON  = 8'd255;
   localparam logic [7:0] EDGE_PIX_OFF = 8'd0;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } trk_state_e;

   // The unused code 11 is folded to none so the buffers only ever hold legal classes.
   function automatic logic [1:0] norm_class(input logic [1:0] cls);
      logic [1:0] res;
      case (cls)
         EDGE_STRONG: res = EDGE_STRONG;
         EDGE_WEAK:   res = EDGE_WEAK;
         default:     res = EDGE_NONE;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/linebuf_2b.sv
// One-line delay of 2-bit edge classes; dout is the value written DEPTH steps ago.
module linebuf_2b #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [1:0]    mem_r [DEPTH];
   logic [PW-1:0] ptr_r;

   assign dout = mem_r[ptr_r];

   // Circular pointer; read happens before the write at the same address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (en) begin
         if (ptr_r == PTR_LAST) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= ptr_r + PW'(1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Storage is never cleared: stale rows are masked downstream by the row counter.
   always_ff @(posedge clk) begin
      if (en) begin
         mem_r[ptr_r] <= din;
      end
   end

endmodule

// File: rtl/hysteresis_tracker.sv
// Single-pass hysteresis over a raster edge-class stream: weak pixels become
// edges only when an 8-neighbour is strong. Flushes the last row after each frame.
module hysteresis_tracker
   import canny_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] edge_type,
   output logic       in_ready,
   output logic       out_valid,
   output logic       edge_out,
   output logic [7:0] edge_pix,
   output logic       frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);
   localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

   trk_state_e    state_r;
   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [FW-1:0] flush_r;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          edge_out_r;
   logic [7:0]    edge_pix_r;
   logic          frame_done_r;
   logic [1:0]    win_l_r [3];
   logic [1:0]    win_m_r [3];

   logic          step_s;
   logic          emit_s;
   logic [1:0]    pix_s;
   logic [1:0]    lb1_s;
   logic [1:0]    lb2_s;
   logic [1:0]    win_n_s [3];
   logic [RW-1:0] ctr_row_s;
   logic [CW-1:0] ctr_col_s;
   logic          top_ok_s, bot_ok_s, left_ok_s, right_ok_s;
   logic          nbr_strong_s;
   logic          edge_s;

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign edge_out   = edge_out_r;
   assign edge_pix   = edge_pix_r;
   assign frame_done = frame_done_r;

   linebuf_2b #(.DEPTH(IMG_W)) u_lb1 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (step_s),
      .din  (pix_s),
      .dout (lb1_s)
   );

   linebuf_2b #(.DEPTH(IMG_W)) u_lb2 (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (step_s),
      .din  (lb1_s),
      .dout (lb2_s)
   );

   // Pipeline step and window-centre coordinates; flush acts as virtual row IMG_H of none.
   always_comb begin
      step_s    = 1'b0;
      emit_s    = 1'b0;
      pix_s     = EDGE_NONE;
      ctr_row_s = '0;
      ctr_col_s = '0;
      case (state_r)
         ST_RUN: begin
            step_s = in_valid;
            pix_s  = norm_class(edge_type);
            emit_s = in_valid && ((row_r > RW'(1)) || ((row_r == RW'(1)) && (col_r != '0)));
            if (col_r == '0) begin
               ctr_row_s = row_r - RW'(2);
               ctr_col_s = COL_LAST;
            end else begin
               ctr_row_s = row_r - RW'(1);
               ctr_col_s = col_r - CW'(1);
            end
         end
         ST_FLUSH: begin
            step_s = 1'b1;
            emit_s = 1'b1;
            if (flush_r == '0) begin
               ctr_row_s = ROW_PEN;
               ctr_col_s = COL_LAST;
            end else begin
               ctr_row_s = ROW_LAST;
               ctr_col_s = CW'(flush_r - FW'(1));
            end
         end
         default: begin
            step_s = 1'b0;
            emit_s = 1'b0;
         end
      endcase
   end

   // Border mask and decision; index 0 of each window column is the row above the centre.
   always_comb begin
      win_n_s[0]   = lb2_s;
      win_n_s[1]   = lb1_s;
      win_n_s[2]   = pix_s;
      top_ok_s     = (ctr_row_s != '0);
      bot_ok_s     = (ctr_row_s != ROW_LAST);
      left_ok_s    = (ctr_col_s != '0);
      right_ok_s   = (ctr_col_s != COL_LAST);
      nbr_strong_s = (top_ok_s && left_ok_s  && (win_l_r[0] == EDGE_STRONG)) ||
                     (left_ok_s              && (win_l_r[1] == EDGE_STRONG)) ||
                     (bot_ok_s && left_ok_s  && (win_l_r[2] == EDGE_STRONG)) ||
                     (top_ok_s               && (win_m_r[0] == EDGE_STRONG)) ||
                     (bot_ok_s               && (win_m_r[2] == EDGE_STRONG)) ||
                     (top_ok_s && right_ok_s && (win_n_s[0] == EDGE_STRONG)) ||
                     (right_ok_s             && (win_n_s[1] == EDGE_STRONG)) ||
                     (bot_ok_s && right_ok_s && (win_n_s[2] == EDGE_STRONG));
      edge_s       = (win_m_r[1] == EDGE_STRONG) ||
                     ((win_m_r[1] == EDGE_WEAK) && nbr_strong_s);
   end

   // Window columns shift left each step; the incoming column stays combinational.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            win_l_r[i] <= EDGE_NONE;
            win_m_r[i] <= EDGE_NONE;
         end
      end else if (step_s) begin
         for (int i = 0; i < 3; i++) begin
            win_l_r[i] <= win_m_r[i];
            win_m_r[i] <= win_n_s[i];
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            win_l_r[i] <= win_l_r[i];
            win_m_r[i] <= win_m_r[i];
         end
      end
   end

   // Counters, RUN/FLUSH control and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_RUN;
         col_r        <= '0;
         row_r        <= '0;
         flush_r      <= '0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         edge_out_r   <= 1'b0;
         edge_pix_r   <= EDGE_PIX_OFF;
         frame_done_r <= 1'b0;
      end else begin
         out_valid_r  <= emit_s;
         edge_out_r   <= emit_s && edge_s;
         edge_pix_r   <= (emit_s && edge_s) ? EDGE_PIX_ON : EDGE_PIX_OFF;
         frame_done_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               if (in_valid) begin
                  if (col_r == COL_LAST) begin
                     col_r <= '0;
                     if (row_r == ROW_LAST) begin
                        row_r      <= '0;
                        state_r    <= ST_FLUSH;
                        in_ready_r <= 1'b0;
                     end else begin
                        row_r <= row_r + RW'(1);
                     end
                  end else begin
                     col_r <= col_r + CW'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_r == FL_LAST) begin
                  flush_r      <= '0;
                  state_r      <= ST_RUN;
                  in_ready_r   <= 1'b1;
                  frame_done_r <= 1'b1;
               end else begin
                  flush_r <= flush_r + FW'(1);
               end
            end
            default: begin
               state_r    <= ST_RUN;
               flush_r    <= '0;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hysteresis_tracker.sv
// Randomized bench for hysteresis_tracker against a whole-frame neighbourhood model.
module tb_hysteresis_tracker;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int NPIX = W * H;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] edge_type;
   logic       in_ready;
   logic       out_valid;
   logic       edge_out;
   logic [7:0] edge_pix;
   logic       frame_done;

   logic [1:0] img [NPIX];
   logic       exp_bits [NPIX];
   int         oidx;
   int         n_checks = 0;
   int         n_errors = 0;

   hysteresis_tracker #(.IMG_W(W), .IMG_H(H)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .edge_type (edge_type),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .edge_out  (edge_out),
      .edge_pix  (edge_pix),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (output index %0d)", tag, got, exp, oidx);
      end
   endtask

   function automatic logic [1:0] cls_at(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 2'b00;
      return img[r * W + c];
   endfunction

   // Spec rule: strong -> edge; weak -> edge iff any in-image 8-neighbour is strong.
   function automatic logic model_edge(input int n);
      int r, c;
      r = n / W;
      c = n % W;
      if (cls_at(r, c) == 2'b10) return 1'b1;
      if (cls_at(r, c) != 2'b01) return 1'b0;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && cls_at(r + dr, c + dc) == 2'b10) return 1'b1;
      return 1'b0;
   endfunction

   task automatic start_frame();
      for (int n = 0; n < NPIX; n++) exp_bits[n] = model_edge(n);
      oidx = 0;
   endtask

   task automatic fill_img(input logic [1:0] v);
      for (int n = 0; n < NPIX; n++) img[n] = v;
   endtask

   task automatic rand_img();
      for (int n = 0; n < NPIX; n++) img[n] = 2'($urandom_range(0, 3));
   endtask

   // Advance to the next falling edge and check any output presented there.
   task automatic tick();
      @(negedge clk);
      if (out_valid) begin
         if (oidx < NPIX) begin
            check_val("edge_out", int'(edge_out), int'(exp_bits[oidx]));
            check_val("edge_pix", int'(edge_pix), exp_bits[oidx] ? 255 : 0);
            check_val("frame_done", int'(frame_done), (oidx == NPIX - 1) ? 1 : 0);
         end else begin
            check_val("extra_out", oidx, NPIX - 1);
         end
         oidx++;
      end else if (frame_done) begin
         check_val("frame_done_idle", int'(frame_done), 0);
      end
   endtask

   task automatic send_pixels(input int n, input int gap);
      int  i   = 0;
      int  cyc = 0;
      bit  acc;
      while (i < n && cyc < 2000) begin
         in_valid  = ($urandom_range(0, 99) >= gap);
         edge_type = img[i];
         acc       = in_valid && in_ready;
         tick();
         if (acc) i++;
         cyc++;
      end
      in_valid = 1'b0;
      if (i < n) check_val("accept_timeout", i, n);
   endtask

   task automatic finish_frame(input bit hold);
      int flen = 0;
      int fov  = 0;
      in_valid  = hold;
      edge_type = 2'b10;
      while (!in_ready && flen < 40) begin
         flen++;
         if (out_valid) fov++;
         tick();
      end
      in_valid = 1'b0;
      check_val("flush_len", flen, W + 1);
      check_val("flush_out_valid", fov, W + 1);
      for (int j = 0; j < 20 && oidx < NPIX; j++) tick();
      check_val("out_count", oidx, NPIX);
      for (int j = 0; j < 4; j++) tick();
   endtask

   task automatic run_frame(input int gap, input bit hold);
      start_frame();
      send_pixels(NPIX, gap);
      finish_frame(hold);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      edge_type = 2'b00;
      oidx      = 0;
      fill_img(2'b00);
      start_frame();
      repeat (3) tick();
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_edge_out", int'(edge_out), 0);
      check_val("rst_edge_pix", int'(edge_pix), 0);
      check_val("rst_frame_done", int'(frame_done), 0);
      check_val("rst_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      tick();

      fill_img(2'b00);
      img[1 * W + 1] = 2'b10;
      run_frame(0, 1'b0);

      fill_img(2'b00);
      img[2 * W + 3] = 2'b01;
      img[1 * W + 2] = 2'b10;
      img[2 * W + 6] = 2'b01;
      run_frame(0, 1'b1);

      fill_img(2'b11);
      run_frame(30, 1'b0);

      fill_img(2'b00);
      img[1 * W + 7] = 2'b10;
      img[2 * W + 0] = 2'b01;
      img[2 * W + 6] = 2'b01;
      run_frame(0, 1'b1);

      for (int f = 0; f < 6; f++) begin
         rand_img();
         run_frame(50, f[0]);
      end

      rand_img();
      start_frame();
      send_pixels(13, 0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("mid_rst_out_valid", int'(out_valid), 0);
      check_val("mid_rst_edge_out", int'(edge_out), 0);
      check_val("mid_rst_edge_pix", int'(edge_pix), 0);
      check_val("mid_rst_frame_done", int'(frame_done), 0);
      check_val("mid_rst_in_ready", int'(in_ready), 1);

      rand_img();
      run_frame(50, 1'b1);
      rand_img();
      run_frame(0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
